// File: rtl/cache_tag_ctrl.sv
// Tag lookup/update controller for a set-associative cache with DAWG way partitioning.
// One request in flight: IDLE -> LOOKUP -> UPDATE -> RESP, with a per-domain replacement pointer.
module cache_tag_ctrl #(
  parameter int WAY_NUM    = 4,
  parameter int INDEX_W    = 10,
  parameter int TAG_W      = 18,
  parameter int DOMAIN_NUM = 2,
  localparam int WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int DOM_W     = (DOMAIN_NUM > 1) ? $clog2(DOMAIN_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [INDEX_W-1:0]                 req_index,
  input  logic [TAG_W-1:0]                   req_tag,
  input  logic                               req_write,
  input  logic [DOM_W-1:0]                   req_domain,
  input  logic [WAY_NUM-1:0]                 req_way_mask,
  output logic [INDEX_W-1:0]                 tag_index,
  output logic [WAY_W-1:0]                   tag_way,
  output logic                               tag_req_we,
  output logic [TAG_W+1:0]                   tag_write,
  input  logic [WAY_NUM-1:0][TAG_W+1:0]      tag_read,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic                               rsp_hit,
  output logic [WAY_W-1:0]                   rsp_way,
  output logic                               rsp_evict,
  output logic [TAG_W-1:0]                   rsp_evict_tag,
  output logic                               rsp_err
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

  localparam int VALID_BIT = TAG_W + 1;
  localparam int DIRTY_BIT = TAG_W;

  state_t               state_reg;
  logic [TAG_W-1:0]     tag_reg;
  logic                 write_reg;
  logic [DOM_W-1:0]     dom_reg;
  logic [WAY_NUM-1:0]   mask_reg;
  logic [WAY_W-1:0]     ptr_reg [DOMAIN_NUM];

  // Decision captured in LOOKUP, consumed in UPDATE
  logic                 hit_reg;
  logic                 err_reg;
  logic [WAY_W-1:0]     way_reg;
  logic                 evict_reg;
  logic [TAG_W-1:0]     evict_tag_reg;
  logic                 ptr_upd_reg;
  logic [WAY_W-1:0]     ptr_new_reg;
  logic                 we_reg;

  logic [WAY_NUM-1:0]   hit_vec;
  logic [WAY_NUM-1:0]   inv_vec;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     ptr_cur;
  logic [WAY_W-1:0]     rot_way;
  logic [WAY_W-1:0]     victim_way;
  logic [WAY_W-1:0]     ptr_after;
  logic [TAG_W+1:0]     victim_entry;
  logic                 victim_dirty;

  generate
    for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way
      assign hit_vec[gi] = mask_reg[gi] & tag_read[gi][VALID_BIT]
                         & (tag_read[gi][TAG_W-1:0] == tag_reg);
      assign inv_vec[gi] = mask_reg[gi] & ~tag_read[gi][VALID_BIT];
    end
  endgenerate

  // Priority encoders scan downward so the lowest matching way wins.
  always_comb begin
    hit_way    = '0;
    inv_way    = '0;
    rot_way    = '0;
    ptr_after  = '0;
    ptr_cur    = ptr_reg[dom_reg];
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (inv_vec[w]) inv_way = WAY_W'(w);
    end
    // A pointer left outside the current mask slides forward to the first owned way.
    for (int k = WAY_NUM - 1; k >= 0; k--) begin
      if (mask_reg[ptr_cur + WAY_W'(k)]) rot_way = ptr_cur + WAY_W'(k);
    end
    victim_way = (|inv_vec) ? inv_way : rot_way;
    // k == WAY_NUM truncates to the victim itself, covering single-way masks.
    for (int k = WAY_NUM; k >= 1; k--) begin
      if (mask_reg[victim_way + WAY_W'(k)]) ptr_after = victim_way + WAY_W'(k);
    end
    victim_entry = tag_read[victim_way];
    victim_dirty = victim_entry[VALID_BIT] & victim_entry[DIRTY_BIT];
  end

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign tag_req_we = we_reg && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tag_reg       <= '0;
      write_reg     <= 1'b0;
      dom_reg       <= '0;
      mask_reg      <= '0;
      hit_reg       <= 1'b0;
      err_reg       <= 1'b0;
      way_reg       <= '0;
      evict_reg     <= 1'b0;
      evict_tag_reg <= '0;
      ptr_upd_reg   <= 1'b0;
      ptr_new_reg   <= '0;
      we_reg        <= 1'b0;
      tag_index     <= '0;
      tag_way       <= '0;
      tag_write     <= '0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_way       <= '0;
      rsp_evict     <= 1'b0;
      rsp_evict_tag <= '0;
      rsp_err       <= 1'b0;
      for (int d = 0; d < DOMAIN_NUM; d++) ptr_reg[d] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            tag_index <= req_index;
            tag_reg   <= req_tag;
            write_reg <= req_write;
            dom_reg   <= req_domain;
            mask_reg  <= req_way_mask;
            state_reg <= LOOKUP;
          end
        end

        LOOKUP: begin
          state_reg     <= UPDATE;
          err_reg       <= (mask_reg == '0);
          evict_reg     <= 1'b0;
          evict_tag_reg <= '0;
          ptr_upd_reg   <= 1'b0;
          ptr_new_reg   <= ptr_after;
          if (mask_reg == '0) begin
            hit_reg <= 1'b0;
            way_reg <= '0;
            we_reg  <= 1'b0;
          end else if (|hit_vec) begin
            // Only a store to a clean line needs the dirty bit set.
            hit_reg   <= 1'b1;
            way_reg   <= hit_way;
            we_reg    <= write_reg & ~tag_read[hit_way][DIRTY_BIT];
            tag_way   <= hit_way;
            tag_write <= {1'b1, 1'b1, tag_reg};
          end else begin
            hit_reg       <= 1'b0;
            way_reg       <= victim_way;
            we_reg        <= 1'b1;
            tag_way       <= victim_way;
            tag_write     <= {1'b1, write_reg, tag_reg};
            evict_reg     <= victim_dirty;
            evict_tag_reg <= victim_dirty ? victim_entry[TAG_W-1:0] : '0;
            ptr_upd_reg   <= ~|inv_vec;
          end
        end

        UPDATE: begin
          we_reg        <= 1'b0;
          if (ptr_upd_reg) ptr_reg[dom_reg] <= ptr_new_reg;
          rsp_valid     <= 1'b1;
          rsp_hit       <= hit_reg;
          rsp_way       <= way_reg;
          rsp_evict     <= evict_reg;
          rsp_evict_tag <= evict_tag_reg;
          rsp_err       <= err_reg;
          state_reg     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl: a behavioural tag memory plus hand-computed
// expectations for hit/miss, DAWG partitioning, victim choice, errors and reset abort.
module tb_cache_tag_ctrl;

  localparam int IDX = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [9:0]        req_index;
  logic [17:0]       req_tag;
  logic              req_write;
  logic [0:0]        req_domain;
  logic [3:0]        req_way_mask;
  logic [9:0]        tag_index;
  logic [1:0]        tag_way;
  logic              tag_req_we;
  logic [19:0]       tag_write;
  logic [3:0][19:0]  tag_read;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [1:0]        rsp_way;
  logic              rsp_evict;
  logic [17:0]       rsp_evict_tag;
  logic              rsp_err;

  int total = 0;
  int bad   = 0;

  logic [19:0] mem [1024][4];
  logic        mem_clr;

  cache_tag_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_write(req_write), .req_domain(req_domain),
    .req_way_mask(req_way_mask),
    .tag_index(tag_index), .tag_way(tag_way), .tag_req_we(tag_req_we),
    .tag_write(tag_write), .tag_read(tag_read),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++)
        for (int w = 0; w < 4; w++) mem[i][w] <= '0;
    end else if (tag_req_we) begin
      mem[tag_index][tag_way] <= tag_write;
    end
  end

  always_comb begin
    for (int w = 0; w < 4; w++) tag_read[w] = mem[tag_index][w];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_req(input string name, input logic dom, input logic [3:0] mask,
                        input logic [17:0] tag, input logic wr,
                        input logic exp_hit, input logic [1:0] exp_way,
                        input logic exp_we, input logic [19:0] exp_wdata,
                        input logic exp_evict, input logic [17:0] exp_etag,
                        input logic chk_etag, input logic exp_err, input int hold);
    check({name, ".req_ready"}, req_ready, 1);
    rsp_ready    = (hold == 0);
    req_valid    = 1'b1;
    req_index    = 10'(IDX);
    req_tag      = tag;
    req_write    = wr;
    req_domain   = dom;
    req_way_mask = mask;
    step();                                   // N+1 LOOKUP
    req_valid = 1'b0;
    check({name, ".n1_rsp_valid"}, rsp_valid, 0);
    check({name, ".tag_index"}, tag_index, IDX);
    check({name, ".n1_we"}, tag_req_we, 0);
    step();                                   // N+2 UPDATE
    check({name, ".we"}, tag_req_we, exp_we);
    if (exp_we) begin
      check({name, ".tag_way"}, tag_way, exp_way);
      check({name, ".tag_write"}, tag_write, exp_wdata);
    end
    check({name, ".n2_rsp_valid"}, rsp_valid, 0);
    step();                                   // N+3 RESP
    check({name, ".rsp_valid"}, rsp_valid, 1);
    check({name, ".rsp_hit"}, rsp_hit, exp_hit);
    check({name, ".rsp_way"}, rsp_way, exp_way);
    check({name, ".rsp_evict"}, rsp_evict, exp_evict);
    if (chk_etag) check({name, ".rsp_evict_tag"}, rsp_evict_tag, exp_etag);
    check({name, ".rsp_err"}, rsp_err, exp_err);
    check({name, ".n3_we"}, tag_req_we, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, ".hold_valid"}, rsp_valid, 1);
      check({name, ".hold_err"}, rsp_err, exp_err);
      check({name, ".hold_way"}, rsp_way, exp_way);
      check({name, ".hold_ready"}, req_ready, 0);
      check({name, ".hold_we"}, tag_req_we, 0);
    end
    rsp_ready = 1'b1;
    $display("txn %s: dom=%0d mask=%b tag=%0h wr=%0d -> hit=%0d way=%0d evict=%0d etag=%0h err=%0d",
             name, dom, mask, tag, wr, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, rsp_err);
    step();                                   // back to IDLE
    check({name, ".done_valid"}, rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_index = '0; req_tag = '0; req_write = 1'b0;
    req_domain = '0; req_way_mask = '0; rsp_ready = 1'b1;
    step(); step(); step();
    mem_clr = 1'b0;
    check("rst.req_ready", req_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.we", tag_req_we, 0);
    check("rst.tag_index", tag_index, 0);
    rst = 1'b0;
    #1;
    check("rst.req_ready_after", req_ready, 1);
    step();

    //       name  dom mask     tag      wr hit way we wdata      ev etag    ce err hold
    do_req("t1_fill",   0, 4'b0011, 18'h123, 0, 0, 0, 1, 20'h80123, 0, 18'h0,   1, 0, 0);
    check("t1.mem_w0", mem[IDX][0], 20'h80123);
    do_req("t2_sthit",  0, 4'b0011, 18'h123, 1, 1, 0, 1, 20'hC0123, 0, 18'h0,   1, 0, 0);
    check("t2.mem_w0", mem[IDX][0], 20'hC0123);
    do_req("t3_dirty",  0, 4'b0011, 18'h123, 1, 1, 0, 0, 20'h0,     0, 18'h0,   1, 0, 0);
    do_req("t4_dom1",   1, 4'b1100, 18'h123, 0, 0, 2, 1, 20'h80123, 0, 18'h0,   1, 0, 0);
    check("t4.mem_w0", mem[IDX][0], 20'hC0123);
    check("t4.mem_w2", mem[IDX][2], 20'h80123);
    do_req("t5_fill1",  0, 4'b0011, 18'h0AA, 0, 0, 1, 1, 20'h800AA, 0, 18'h0,   1, 0, 0);
    do_req("t6_evict",  0, 4'b0011, 18'h200, 0, 0, 0, 1, 20'h80200, 1, 18'h123, 1, 0, 0);
    do_req("t7_ptr",    0, 4'b0011, 18'h300, 0, 0, 1, 1, 20'h80300, 0, 18'h0,   0, 0, 0);
    do_req("t8_err",    0, 4'b0000, 18'h400, 0, 0, 0, 0, 20'h0,     0, 18'h0,   1, 1, 5);
    do_req("t9_ptr0",   0, 4'b0011, 18'h400, 0, 0, 0, 1, 20'h80400, 0, 18'h0,   0, 0, 0);
    check("t9.mem_w1", mem[IDX][1], 20'h80300);

    // Reset during UPDATE of a miss (victim would be way1)
    req_valid = 1'b1; req_index = 10'(IDX); req_tag = 18'h500; req_write = 1'b1;
    req_domain = 1'b0; req_way_mask = 4'b0011;
    step();
    req_valid = 1'b0;
    step();
    check("t10.pre_rst_we", tag_req_we, 1);
    rst = 1'b1;
    #1;
    check("t10.rst_we", tag_req_we, 0);
    step();
    check("t10.rsp_valid", rsp_valid, 0);
    check("t10.tag_index", tag_index, 0);
    check("t10.tag_write", tag_write, 0);
    check("t10.req_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    #1;
    check("t10.req_ready", req_ready, 1);
    check("t10.mem_w1", mem[IDX][1], 20'h80300);
    $display("txn t10_rst: reset during UPDATE, write suppressed");
    step();

    // Pointer was reset to 0, so the next domain-0 miss replaces way0
    do_req("t11_post",  0, 4'b0011, 18'h600, 0, 0, 0, 1, 20'h80600, 0, 18'h0,   0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
